// File: rtl/intersection_pkg.sv
// Shared definitions for the highway/country intersection scheduler:
// light encodings, FSM state encodings, default dwell times and a helper
// that sizes the phase timer from the configured dwells.
package intersection_pkg;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'd0,
        LIGHT_YELLOW = 2'd1,
        LIGHT_GREEN  = 2'd2
    } light_t;

    // Encoding 3'd7 is unused and is treated as illegal by the scheduler.
    typedef enum logic [2:0] {
        HWY_GREEN    = 3'd0,
        HWY_YELLOW   = 3'd1,
        ALL_RED_A    = 3'd2,
        CNTRY_GREEN  = 3'd3,
        CNTRY_YELLOW = 3'd4,
        PED_WALK     = 3'd5,
        ALL_RED_B    = 3'd6
    } state_t;

    localparam int DEF_MIN_GREEN       = 8;
    localparam int DEF_YELLOW_TIME     = 3;
    localparam int DEF_ALL_RED_TIME    = 2;
    localparam int DEF_MAX_CNTRY_GREEN = 16;
    localparam int DEF_WALK_TIME       = 10;

    // Largest of the five dwells; the timer must hold (largest dwell - 1).
    function automatic int max_dwell(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase dwell counter: loads a value, counts down once per cycle and
// sticks at zero. The zero flag marks the last cycle of a timed phase.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    // Load has priority; otherwise decrement until zero and hold there.
    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/intersection_scheduler.sv
// Traffic-light scheduler for a highway / country-road crossing with an
// optional pedestrian phase.
//
// Build option: define INTERSECTION_PED_CROSSING_EN to include the
// pedestrian walk phase, the pending-request latch and the round-robin
// tie breaker between country traffic and pedestrians. Without it the
// ped_req port is ignored and walk is held at 0.
//
// Outputs decode from the state register only, so sensor and button
// inputs never reach the lamps combinationally.
module intersection_scheduler
    import intersection_pkg::*;
#(
    parameter int MIN_GREEN       = DEF_MIN_GREEN,
    parameter int YELLOW_TIME     = DEF_YELLOW_TIME,
    parameter int ALL_RED_TIME    = DEF_ALL_RED_TIME,
    parameter int MAX_CNTRY_GREEN = DEF_MAX_CNTRY_GREEN,
    parameter int WALK_TIME       = DEF_WALK_TIME
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       X,
    input  logic       ped_req,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk
);

    localparam int DMAX = max_dwell(MIN_GREEN, YELLOW_TIME, ALL_RED_TIME,
                                    MAX_CNTRY_GREEN, WALK_TIME);
    localparam int TW   = (DMAX > 1) ? $clog2(DMAX) : 1;

    state_t          state;
    state_t          state_next;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic [TW-1:0]   unused_tmr_count;
    logic            tmr_zero;
    logic            ped_want;

    // Dwell of a phase minus one: the value the timer starts from on entry.
    function automatic logic [TW-1:0] dwell_m1(input state_t s);
        case (s)
            HWY_GREEN:    return TW'(MIN_GREEN - 1);
            HWY_YELLOW:   return TW'(YELLOW_TIME - 1);
            ALL_RED_A:    return TW'(ALL_RED_TIME - 1);
            CNTRY_GREEN:  return TW'(MAX_CNTRY_GREEN - 1);
            CNTRY_YELLOW: return TW'(YELLOW_TIME - 1);
            PED_WALK:     return TW'(WALK_TIME - 1);
            ALL_RED_B:    return TW'(ALL_RED_TIME - 1);
            default:      return TW'(MIN_GREEN - 1);
        endcase
    endfunction

`ifdef INTERSECTION_PED_CROSSING_EN
    logic ped_pending;
    logic rr_ped;       // 1: pedestrians were served last, 0: country
    logic enter_walk;
    logic enter_cntry;

    assign enter_walk  = (state_next == PED_WALK)    && (state != PED_WALK);
    assign enter_cntry = (state_next == CNTRY_GREEN) && (state != CNTRY_GREEN);
    assign ped_want    = ped_pending;

    // Latch button presses until the walk phase is entered; entry wins over
    // a press in the same cycle. Remember which side was served last.
    always_ff @(posedge clk) begin
        if (clear) begin
            ped_pending <= 1'b0;
            rr_ped      <= 1'b1;
        end else begin
            if (enter_walk) begin
                ped_pending <= 1'b0;
            end else if (ped_req && (state != PED_WALK)) begin
                ped_pending <= 1'b1;
            end
            if (enter_cntry) begin
                rr_ped <= 1'b0;
            end else if (enter_walk) begin
                rr_ped <= 1'b1;
            end
        end
    end
`else
    logic unused_ped_req;

    assign unused_ped_req = ped_req;
    assign ped_want       = 1'b0;
`endif

    // Timer restarts on clear and on every phase change.
    assign tmr_load = clear || (state_next != state);
    assign tmr_val  = clear ? TW'(MIN_GREEN - 1) : dwell_m1(state_next);

    phase_timer #(
        .W (TW)
    ) u_phase_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (unused_tmr_count),
        .zero     (tmr_zero)
    );

    // State register; clear forces highway green from any state.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= HWY_GREEN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; unknown encodings fall back to highway green.
    always_comb begin
        state_next = state;
        case (state)
            HWY_GREEN: begin
                if (tmr_zero && (X || ped_want)) state_next = HWY_YELLOW;
            end
            HWY_YELLOW: begin
                if (tmr_zero) state_next = ALL_RED_A;
            end
            ALL_RED_A: begin
                if (tmr_zero) begin
`ifdef INTERSECTION_PED_CROSSING_EN
                    if (X && ped_pending) begin
                        state_next = rr_ped ? CNTRY_GREEN : PED_WALK;
                    end else if (X) begin
                        state_next = CNTRY_GREEN;
                    end else if (ped_pending) begin
                        state_next = PED_WALK;
                    end else begin
                        state_next = HWY_GREEN;
                    end
`else
                    state_next = X ? CNTRY_GREEN : HWY_GREEN;
`endif
                end
            end
            CNTRY_GREEN: begin
                if (!X || tmr_zero) state_next = CNTRY_YELLOW;
            end
            CNTRY_YELLOW: begin
                if (tmr_zero) state_next = ALL_RED_B;
            end
`ifdef INTERSECTION_PED_CROSSING_EN
            PED_WALK: begin
                if (tmr_zero) state_next = ALL_RED_B;
            end
`endif
            ALL_RED_B: begin
                if (tmr_zero) state_next = HWY_GREEN;
            end
            default: begin
                state_next = HWY_GREEN;
            end
        endcase
    end

    // Lamp decode from the state register alone; unknown states show all red.
    always_comb begin
        hwy   = LIGHT_RED;
        cntry = LIGHT_RED;
        walk  = 1'b0;
        case (state)
            HWY_GREEN:    hwy   = LIGHT_GREEN;
            HWY_YELLOW:   hwy   = LIGHT_YELLOW;
            CNTRY_GREEN:  cntry = LIGHT_GREEN;
            CNTRY_YELLOW: cntry = LIGHT_YELLOW;
`ifdef INTERSECTION_PED_CROSSING_EN
            PED_WALK:     walk  = 1'b1;
`endif
            default:      ;
        endcase
    end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: directed scenarios with fixed expected
// timelines plus randomized sensor/button/clear traffic, all checked each
// cycle against a phase-and-age reference model.
module tb_intersection_scheduler;

    localparam int MIN_GREEN       = 8;
    localparam int YELLOW_TIME     = 3;
    localparam int ALL_RED_TIME    = 2;
    localparam int MAX_CNTRY_GREEN = 16;
    localparam int WALK_TIME       = 10;

    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] G = 2'd2;

`ifdef INTERSECTION_PED_CROSSING_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    localparam int PH_HG  = 0;
    localparam int PH_HY  = 1;
    localparam int PH_ARA = 2;
    localparam int PH_CG  = 3;
    localparam int PH_CY  = 4;
    localparam int PH_PW  = 5;
    localparam int PH_ARB = 6;

    logic       clk = 1'b0;
    logic       clear;
    logic       X;
    logic       ped_req;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       walk;

    int n_cmp = 0;
    int n_mis = 0;

    int m_phase;
    int m_age;
    bit m_pend;
    bit m_last_ped;

    intersection_scheduler #(
        .MIN_GREEN       (MIN_GREEN),
        .YELLOW_TIME     (YELLOW_TIME),
        .ALL_RED_TIME    (ALL_RED_TIME),
        .MAX_CNTRY_GREEN (MAX_CNTRY_GREEN),
        .WALK_TIME       (WALK_TIME)
    ) dut (
        .clk     (clk),
        .clear   (clear),
        .X       (X),
        .ped_req (ped_req),
        .hwy     (hwy),
        .cntry   (cntry),
        .walk    (walk)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_hwy(input int ph);
        if (ph == PH_HG) return G;
        if (ph == PH_HY) return Y;
        return R;
    endfunction

    function automatic logic [1:0] exp_cntry(input int ph);
        if (ph == PH_CG) return G;
        if (ph == PH_CY) return Y;
        return R;
    endfunction

    // Reference: each phase tracked by how many cycles it has been shown.
    task automatic model_step(input bit x, input bit p, input bit c);
        int nxt;
        if (c) begin
            m_phase    = PH_HG;
            m_age      = 0;
            m_pend     = 1'b0;
            m_last_ped = 1'b1;
            return;
        end
        nxt = m_phase;
        case (m_phase)
            PH_HG:  if (m_age >= MIN_GREEN - 1 && (x || m_pend)) nxt = PH_HY;
            PH_HY:  if (m_age == YELLOW_TIME - 1) nxt = PH_ARA;
            PH_ARA: if (m_age == ALL_RED_TIME - 1) begin
                        if (x && m_pend)  nxt = m_last_ped ? PH_CG : PH_PW;
                        else if (x)       nxt = PH_CG;
                        else if (m_pend)  nxt = PH_PW;
                        else              nxt = PH_HG;
                    end
            PH_CG:  if (!x || m_age == MAX_CNTRY_GREEN - 1) nxt = PH_CY;
            PH_CY:  if (m_age == YELLOW_TIME - 1) nxt = PH_ARB;
            PH_PW:  if (m_age == WALK_TIME - 1) nxt = PH_ARB;
            PH_ARB: if (m_age == ALL_RED_TIME - 1) nxt = PH_HG;
            default: nxt = PH_HG;
        endcase
        if (nxt == PH_CG && m_phase != PH_CG) m_last_ped = 1'b0;
        if (nxt == PH_PW && m_phase != PH_PW) begin
            m_last_ped = 1'b1;
            m_pend     = 1'b0;
        end else if (PED_EN && p && m_phase != PH_PW) begin
            m_pend = 1'b1;
        end
        m_age   = (nxt == m_phase) ? m_age + 1 : 0;
        m_phase = nxt;
    endtask

    // Called at a negedge: check the current cycle, then drive and advance.
    task automatic tick(input bit x, input bit p, input bit c, input string tag);
        check({tag, "_hwy"},   hwy,   exp_hwy(m_phase));
        check({tag, "_cntry"}, cntry, exp_cntry(m_phase));
        check({tag, "_walk"},  walk,  (m_phase == PH_PW));
        X       = x;
        ped_req = p;
        clear   = c;
        @(posedge clk);
        model_step(x, p, c);
        @(negedge clk);
    endtask

    task automatic do_reset();
        X       = 1'b0;
        ped_req = 1'b0;
        clear   = 1'b1;
        repeat (2) @(posedge clk);
        model_step(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        clear = 1'b0;
        check("rst_hwy",   hwy,   G);
        check("rst_cntry", cntry, R);
        check("rst_walk",  walk,  1'b0);
    endtask

    initial begin
        bit xr;
        bit pr;
        bit cr;

        // Idle: highway green forever with no demand
        do_reset();
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (cyc == 99) check("idle_hwy99", hwy, G);
            tick(1'b0, 1'b0, 1'b0, "idle");
        end

        // Country road held busy: capped by the maximum country green
        do_reset();
        for (int cyc = 0; cyc < 70; cyc++) begin
            case (cyc)
                7:  check("max_hwy7",    hwy,   G);
                8:  check("max_hwy8",    hwy,   Y);
                11: check("max_hwy11",   hwy,   R);
                13: check("max_cntry13", cntry, G);
                28: check("max_cntry28", cntry, G);
                29: check("max_cntry29", cntry, Y);
                32: check("max_cntry32", cntry, R);
                34: check("max_hwy34",   hwy,   G);
                42: check("max_hwy42",   hwy,   Y);
                default: ;
            endcase
            tick(1'b1, 1'b0, 1'b0, "max");
        end

        // Single pedestrian press with no country traffic
        do_reset();
        for (int cyc = 0; cyc < 45; cyc++) begin
            case (cyc)
                8:  check("ped_hwy8",   hwy,  PED_EN ? Y : G);
                13: check("ped_walk13", walk, PED_EN);
                22: check("ped_walk22", walk, PED_EN);
                23: check("ped_walk23", walk, 1'b0);
                25: check("ped_hwy25",  hwy,  G);
                40: check("ped_hwy40",  hwy,  G);
                default: ;
            endcase
            tick(1'b0, (cyc == 2), 1'b0, "ped");
        end

        // Tie between country and pedestrian: country first, then walk
        do_reset();
        for (int cyc = 0; cyc < 50; cyc++) begin
            case (cyc)
                13: check("tie_cntry13", cntry, G);
                15: check("tie_cntry15", cntry, G);
                16: check("tie_cntry16", cntry, Y);
                34: check("tie_walk34",  walk,  PED_EN);
                default: ;
            endcase
            tick((cyc < 15), (cyc == 0), 1'b0, "tie");
        end

        // Clear in the middle of country green, with a press pending
        do_reset();
        for (int cyc = 0; cyc < 45; cyc++) begin
            case (cyc)
                20: check("mid_cntry20", cntry, G);
                21: begin
                        check("mid_hwy21",   hwy,   G);
                        check("mid_cntry21", cntry, R);
                    end
                40: check("mid_hwy40", hwy, G);
                default: ;
            endcase
            tick((cyc <= 20), (cyc == 15), (cyc == 20), "mid");
        end

        // Randomized traffic with occasional clears
        do_reset();
        xr = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(7) == 0) xr = ~xr;
            pr = ($urandom_range(15) == 0);
            cr = ($urandom_range(299) == 0);
            tick(xr, pr, cr, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
